// File: rtl/iter_alu_if.sv
// Request/response bundle for the iterative ALU: operands and opcode in, registered result out.
interface iter_alu_if;
    logic        valid_in;
    logic        ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        valid_out;
    logic        illegal;

    modport master (
        output valid_in, ALUControl, SrcA, SrcB,
        input  ready, ALUResult, Zero, valid_out, illegal
    );

    modport slave (
        input  valid_in, ALUControl, SrcA, SrcB,
        output ready, ALUResult, Zero, valid_out, illegal
    );
endinterface

// File: rtl/iter_alu.sv
// Iterative 32-bit ALU: single-cycle ops finish one cycle after accept; shifts move one bit per cycle (latency shamt+1).
// Accepts only in IDLE (ready); no new request is taken while shifting or during the one-cycle DONE result pulse.
module iter_alu (
    input  logic        clk,
    input  logic        reset,
    iter_alu_if.slave   bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic        vout_q, vout_d;
    logic        ill_q, ill_d;

    logic [31:0] alu_res;
    logic        alu_ill;
    logic        in_is_shift;
    logic [31:0] shifted;

    // Single-cycle result straight from the request operands.
    always_comb begin
        alu_res = 32'h0;
        alu_ill = 1'b0;
        case (bus.ALUControl)
            OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
            OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
            OP_SLT:  alu_res = {31'h0, $signed(bus.SrcA) < $signed(bus.SrcB)};
            OP_SLTU: alu_res = {31'h0, bus.SrcA < bus.SrcB};
            OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
            OP_OR:   alu_res = bus.SrcA | bus.SrcB;
            OP_AND:  alu_res = bus.SrcA & bus.SrcB;
            OP_SLL, OP_SRA, OP_SRL: alu_res = 32'h0;
            default: alu_ill = 1'b1;
        endcase
    end

    assign in_is_shift = (bus.ALUControl == OP_SLL) || (bus.ALUControl == OP_SRA) ||
                         (bus.ALUControl == OP_SRL);

    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {work_q[30:0], 1'b0};
            OP_SRA:  shifted = {work_q[31], work_q[31:1]};
            default: shifted = {1'b0, work_q[31:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        vout_d  = 1'b0;
        ill_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    op_d = bus.ALUControl;
                    if (in_is_shift) begin
                        work_d = bus.SrcA;
                        cnt_d  = bus.SrcB[4:0];
                        if (bus.SrcB[4:0] == 5'd0) begin
                            res_d   = bus.SrcA;
                            zero_d  = (bus.SrcA == 32'h0);
                            vout_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == 32'h0);
                        ill_d   = alu_ill;
                        vout_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - 5'd1;
                // Last step: publish the final shifted value alongside the pulse.
                if (cnt_q == 5'd1) begin
                    res_d   = shifted;
                    zero_d  = (shifted == 32'h0);
                    vout_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 4'h0;
            work_q  <= 32'h0;
            cnt_q   <= 5'd0;
            res_q   <= 32'h0;
            zero_q  <= 1'b1;
            vout_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            vout_q  <= vout_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;
    assign bus.valid_out = vout_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_iter_alu.sv
// Randomized and directed checks of iter_alu against a plain-arithmetic reference model.
module tb_iter_alu;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] last_res;

    iter_alu_if bus ();
    iter_alu dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {illegal, result}.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        int          sh;
        sh  = int'(b % 32);
        ill = 1'b0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << sh;
            4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r = (a < b) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = $signed(a) >>> sh;
            4'd7: r = a >> sh;
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        return {ill, r};
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd2 || op == 4'd6 || op == 4'd7) return int'(b % 32) + 1;
        return 1;
    endfunction

    // Called and returns at a falling edge. hold keeps valid_in high through DONE.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
        logic [32:0] m;
        int          lat, rdy_low, w, elat;
        bit          stable, ill_low;
        m    = model(op, a, b);
        elat = exp_latency(op, b);
        w = 0;
        while (!bus.ready && w < 100) begin @(negedge clk); w++; end
        if (!bus.ready) begin check({tag, "_ready_wait"}, 32'd0, 32'd1); return; end
        bus.valid_in   = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.valid_in   = 1'b0;
            bus.ALUControl = 4'($urandom);
            bus.SrcA       = $urandom;
            bus.SrcB       = $urandom;
        end
        lat = 0; rdy_low = 0; stable = 1'b1; ill_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.valid_out) begin
                if (!bus.ready) rdy_low++;
                if (bus.ALUResult !== last_res) stable = 1'b0;
                if (bus.illegal) ill_low = 1'b0;
            end
        end while (!bus.valid_out && lat < 40);
        if (!bus.valid_out) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            bus.valid_in = 1'b0;
            return;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_ready_low"}, 32'(rdy_low), 32'(elat - 1));
        check({tag, "_hold_and_no_illegal"}, {30'd0, stable, ill_low}, 32'd3);
        check({tag, "_result"}, bus.ALUResult, m[31:0]);
        check({tag, "_zero"}, 32'(bus.Zero), 32'(m[31:0] == 32'd0));
        check({tag, "_illegal"}, 32'(bus.illegal), 32'(m[32]));
        last_res = m[31:0];
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'd0, bus.valid_out, bus.ready}, 32'd1);
        bus.valid_in = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int          pulses;
        reset          = 1'b1;
        bus.valid_in   = 1'b1;
        bus.ALUControl = 4'd0;
        bus.SrcA       = 32'd9;
        bus.SrcB       = 32'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {bus.ALUResult[29:0], bus.Zero, bus.ready}, 32'd3);
        check("reset_pulses", {30'd0, bus.valid_out, bus.illegal}, 32'd0);
        bus.valid_in = 1'b0;
        reset        = 1'b0;
        last_res     = 32'd0;
        @(negedge clk);

        do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("sra31", 4'd6, 32'h8000_0000, 32'h0000_001F, 1'b0);
        do_op("srl31", 4'd7, 32'h8000_0000, 32'h0000_001F, 1'b0);
        do_op("sll0", 4'd2, 32'h1, 32'hFFFF_FFE0, 1'b0);
        do_op("sll4", 4'd2, 32'h1, 32'd4, 1'b0);
        do_op("illegal", 4'b1100, 32'd5, 32'd3, 1'b1);
        do_op("sub", 4'd1, 32'd3, 32'd5, 1'b0);

        // Abort a shift with reset; requests during reset must be dropped.
        bus.valid_in = 1'b1; bus.ALUControl = 4'd2; bus.SrcA = 32'h1; bus.SrcB = 32'd10;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.valid_in = 1'b1; bus.ALUControl = 4'd0; bus.SrcA = 32'd7; bus.SrcB = 32'd8;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.valid_in = 1'b0;
        @(negedge clk);
        check("rst_abort_ready", 32'(bus.ready), 32'd1);
        check("rst_abort_result", bus.ALUResult, 32'd0);
        check("rst_abort_zero", 32'(bus.Zero), 32'd1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.valid_out) pulses++;
            @(negedge clk);
        end
        check("rst_abort_no_pulse", 32'(pulses), 32'd0);
        last_res = 32'd0;
        do_op("post_rst_add", 4'd0, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 3 == 0) a = 32'($urandom_range(0, 3));
            do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
